// File: rtl/core_pkg.sv
/*------------------------------------------------------------------------------
 * Module   : core_pkg
 * Summary  : Shared instruction-class encodings, opcode constants, field
 *            positions and the decode classifier used by decode_issue.
 * Revision : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

package core_pkg;

  typedef enum logic [2:0] {
    IC_NOP     = 3'd0,
    IC_ALU_R   = 3'd1,
    IC_ALU_I   = 3'd2,
    IC_LOAD    = 3'd3,
    IC_STORE   = 3'd4,
    IC_BRANCH  = 3'd5,
    IC_JUMP    = 3'd6,
    IC_ILLEGAL = 3'd7
  } iclass_e;

  localparam logic [5:0] OP_RTYPE     = 6'b000000;
  localparam logic [5:0] OP_J         = 6'b000010;
  localparam logic [5:0] OP_JAL       = 6'b000011;
  localparam logic [5:0] OP_BC        = 6'b110010;
  localparam logic [5:0] OP_LW        = 6'b100011;
  localparam logic [5:0] OP_SW        = 6'b101011;
  localparam logic [4:0] OP_BRANCH_HI = 5'b00010;
  localparam logic [2:0] OP_ALUI_HI   = 3'b001;
  localparam logic [5:0] FN_JR        = 6'b001000;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int JT_MSB  = 25;
  localparam int JT_LSB  = 0;

  typedef struct packed {
    iclass_e    cls;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] dest;
  } dec_t;

  // The all-zero word is tested first so it is not mistaken for an R-type shift.
  function automatic dec_t classify(input logic [31:0] cmd, input logic [4:0] link);
    logic [5:0] op;
    logic [5:0] fn;
    dec_t       d;
    op       = cmd[OP_MSB:OP_LSB];
    fn       = cmd[FN_MSB:FN_LSB];
    d.cls    = IC_ILLEGAL;
    d.use_rs = 1'b0;
    d.use_rt = 1'b0;
    d.dest   = 5'd0;
    if (cmd == 32'd0) begin
      d.cls = IC_NOP;
    end else if (op == OP_RTYPE) begin
      if (fn == FN_JR) begin
        d.cls    = IC_JUMP;
        d.use_rs = 1'b1;
      end else begin
        d.cls    = IC_ALU_R;
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
        d.dest   = cmd[RD_MSB:RD_LSB];
      end
    end else if (op[5:3] == OP_ALUI_HI) begin
      d.cls    = IC_ALU_I;
      d.use_rs = 1'b1;
      d.dest   = cmd[RT_MSB:RT_LSB];
    end else if (op == OP_LW) begin
      d.cls    = IC_LOAD;
      d.use_rs = 1'b1;
      d.dest   = cmd[RT_MSB:RT_LSB];
    end else if (op == OP_SW) begin
      d.cls    = IC_STORE;
      d.use_rs = 1'b1;
      d.use_rt = 1'b1;
    end else if (op[5:1] == OP_BRANCH_HI) begin
      d.cls    = IC_BRANCH;
      d.use_rs = 1'b1;
      d.use_rt = 1'b1;
    end else if (op == OP_BC) begin
      d.cls = IC_BRANCH;
    end else if (op == OP_J) begin
      d.cls = IC_JUMP;
    end else if (op == OP_JAL) begin
      d.cls  = IC_JUMP;
      d.dest = link;
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_issue_scoreboard.sv
/*------------------------------------------------------------------------------
 * Module   : scoreboard
 * Summary  : Busy-bit array with one set port, one clear port and two read
 *            ports. DECODE_WB_BYPASS_EN hides a register being cleared this
 *            cycle from the read ports.
 * Revision : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module scoreboard #(
  parameter int NREG = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_addr,
  input  logic       clr_en,
  input  logic [4:0] clr_addr,
  input  logic [4:0] rd_addr_a,
  input  logic [4:0] rd_addr_b,
  output logic       busy_a,
  output logic       busy_b
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_byp_a;
  logic            w_byp_b;

  // Set is applied after clear so a same-cycle set on the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (clr_en) w_busy_nxt[clr_addr] = 1'b0;
    if (set_en) w_busy_nxt[set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

`ifdef DECODE_WB_BYPASS_EN
  assign w_byp_a = clr_en && (clr_addr == rd_addr_a);
  assign w_byp_b = clr_en && (clr_addr == rd_addr_b);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  assign busy_a = r_busy[rd_addr_a] & ~w_byp_a;
  assign busy_b = r_busy[rd_addr_b] & ~w_byp_b;

endmodule

`default_nettype wire

// File: rtl/decode_issue.sv
/*------------------------------------------------------------------------------
 * Module   : decode_issue
 * Summary  : Decode and issue stage with register busy scoreboard.
 *            Optional macro DECODE_WB_BYPASS_EN allows issue in the writeback
 *            cycle of a blocking source.
 * Revision : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module decode_issue
  import core_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int LINK_REG = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] pc_in,
  input  logic [31:0] command_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_enable,
  input  logic [4:0]  wb_addr,
  output logic        done,
  output logic        hazard,
  output logic [31:0] pc,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  shamt,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  rd_addr,
  output logic [31:0] imm,
  output logic [31:0] jtarget,
  output logic [2:0]  iclass
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  state_e      r_state;
  logic [31:0] r_pc_lat;
  logic [31:0] r_cmd_lat;
  dec_t        w_dec;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic        w_busy_rs;
  logic        w_busy_rt;
  logic        w_pending;
  logic        w_blocked;
  logic        w_issue;

  assign w_dec     = classify(r_cmd_lat, 5'(LINK_REG));
  assign w_rs      = r_cmd_lat[RS_MSB:RS_LSB];
  assign w_rt      = r_cmd_lat[RT_MSB:RT_LSB];
  assign w_pending = (r_state == S_DECODE) || (r_state == S_HOLD);
  assign w_blocked = (w_dec.use_rs && w_busy_rs) || (w_dec.use_rt && w_busy_rt);
  assign w_issue   = w_pending && !flush && !stall && !w_blocked;

  scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (w_issue && (w_dec.dest != 5'd0)),
    .set_addr  (w_dec.dest),
    .clr_en    (wb_enable),
    .clr_addr  (wb_addr),
    .rd_addr_a (w_rs),
    .rd_addr_b (w_rt),
    .busy_a    (w_busy_rs),
    .busy_b    (w_busy_rt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc_lat  <= '0;
      r_cmd_lat <= '0;
      done      <= 1'b0;
      hazard    <= 1'b0;
      pc        <= '0;
      opcode    <= '0;
      funct     <= '0;
      shamt     <= '0;
      rs_addr   <= '0;
      rt_addr   <= '0;
      rd_addr   <= '0;
      imm       <= '0;
      jtarget   <= '0;
      iclass    <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_pc_lat  <= pc_in;
            r_cmd_lat <= command_in;
            r_state   <= S_DECODE;
          end
        end
        S_DECODE, S_HOLD: begin
          if (flush) begin
            hazard  <= 1'b0;
            r_state <= S_IDLE;
          end else if (stall) begin
            r_state <= r_state;
          end else if (w_blocked) begin
            hazard  <= 1'b1;
            r_state <= S_HOLD;
          end else begin
            done    <= 1'b1;
            hazard  <= 1'b0;
            pc      <= r_pc_lat;
            opcode  <= r_cmd_lat[OP_MSB:OP_LSB];
            funct   <= r_cmd_lat[FN_MSB:FN_LSB];
            shamt   <= r_cmd_lat[SH_MSB:SH_LSB];
            rs_addr <= w_rs;
            rt_addr <= w_rt;
            rd_addr <= w_dec.dest;
            imm     <= {{16{r_cmd_lat[IMM_MSB]}}, r_cmd_lat[IMM_MSB:IMM_LSB]};
            jtarget <= {4'b0000, r_cmd_lat[JT_MSB:JT_LSB], 2'b00};
            iclass  <= w_dec.cls;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_issue.sv
/*------------------------------------------------------------------------------
 * Module   : tb_decode_issue
 * Summary  : Directed self-checking bench for decode_issue.
 * Revision : 1.0  initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] pc_in;
  logic [31:0] command_in;
  logic        stall;
  logic        flush;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic        done;
  logic        hazard;
  logic [31:0] pc;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [31:0] imm;
  logic [31:0] jtarget;
  logic [2:0]  iclass;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_issue u_dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pc_in      (pc_in),
    .command_in (command_in),
    .stall      (stall),
    .flush      (flush),
    .wb_enable  (wb_enable),
    .wb_addr    (wb_addr),
    .done       (done),
    .hazard     (hazard),
    .pc         (pc),
    .opcode     (opcode),
    .funct      (funct),
    .shamt      (shamt),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_addr    (rd_addr),
    .imm        (imm),
    .jtarget    (jtarget),
    .iclass     (iclass)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle; returns in the DECODE cycle.
  task automatic start(input logic [31:0] p, input logic [31:0] c);
    pc_in      = p;
    command_in = c;
    enable     = 1'b1;
    tick();
    enable     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pc_in = '0; command_in = '0;
    stall = 1'b0; flush = 1'b0; wb_enable = 1'b0; wb_addr = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_done",   done,    0);
    chk("rst_hazard", hazard,  0);
    chk("rst_pc",     pc,      0);
    chk("rst_iclass", iclass,  0);
    chk("rst_rd",     rd_addr, 0);
    chk("rst_imm",    imm,     0);

    // add r8,r9,r10
    start(32'h100, 32'h012A4020);
    chk("add_n1_done", done, 0);
    tick();
    chk("add_done",   done,    1);
    chk("add_iclass", iclass,  1);
    chk("add_rd",     rd_addr, 8);
    chk("add_rs",     rs_addr, 9);
    chk("add_rt",     rt_addr, 10);
    chk("add_funct",  funct,   6'h20);
    chk("add_pc",     pc,      32'h100);

    // lw r11,4(r8) blocked on r8
    start(32'h104, 32'h8D0B0004);
    tick();
    chk("lw_hazard", hazard, 1);
    chk("lw_nodone", done,   0);
    tick();
    chk("lw_hold_hazard", hazard, 1);
    chk("lw_hold_nodone", done,   0);
    wb_enable = 1'b1; wb_addr = 5'd8;
    tick();
    wb_enable = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    chk("lw_byp_done", done, 1);
`else
    chk("lw_wb1_nodone", done, 0);
    tick();
    chk("lw_done", done, 1);
`endif
    chk("lw_rd",     rd_addr, 11);
    chk("lw_iclass", iclass,  3);
    chk("lw_hazclr", hazard,  0);
    chk("lw_imm",    imm,     32'h4);
    chk("lw_pc",     pc,      32'h104);

    // jal 0x100
    start(32'h108, 32'h0C000040);
    tick();
    chk("jal_done",    done,    1);
    chk("jal_iclass",  iclass,  6);
    chk("jal_rd",      rd_addr, 31);
    chk("jal_jtarget", jtarget, 32'h100);

    // beq r8,r9,-2 : both sources free
    start(32'h10C, 32'h1109FFFE);
    tick();
    chk("beq_done",   done,    1);
    chk("beq_imm",    imm,     32'hFFFFFFFE);
    chk("beq_iclass", iclass,  5);
    chk("beq_rd",     rd_addr, 0);

    // opcode 0x3F is illegal but still issues
    start(32'h110, 32'hFC000000);
    tick();
    chk("ill_done",   done,   1);
    chk("ill_iclass", iclass, 7);
    chk("ill_opcode", opcode, 6'h3F);
    tick();
    chk("ill_pulse", done, 0);

    // add r1,r11,r0 blocked on r11, then flushed
    start(32'h114, 32'h01600820);
    tick();
    chk("fl_hazard", hazard, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_nodone", done,   0);
    chk("fl_hazclr", hazard, 0);
    chk("fl_pc_kept", pc, 32'h110);
    tick();
    chk("fl_still_nodone", done, 0);
    start(32'h118, 32'h01600820);
    tick();
    chk("fl_r11_busy", hazard, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // j 0x40 with a 3-cycle stall in DECODE
    start(32'h11C, 32'h08000010);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_nodone", done, 0);
    end
    stall = 1'b0;
    tick();
    chk("st_done",    done,    1);
    chk("st_jtarget", jtarget, 32'h40);
    chk("st_iclass",  iclass,  6);

    // add r8,r0,r0 issued while r8 is written back: set wins
    start(32'h120, 32'h00004020);
    wb_enable = 1'b1; wb_addr = 5'd8;
    tick();
    wb_enable = 1'b0;
    chk("sc_done", done,    1);
    chk("sc_rd",   rd_addr, 8);
    start(32'h124, 32'h8D0B0004);
    tick();
    chk("sc_r8_busy", hazard, 1);
    chk("sc_nodone",  done,   0);

    // reset while in HOLD
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_hazard",  hazard,  0);
    chk("mr_done",    done,    0);
    chk("mr_pc",      pc,      0);
    chk("mr_iclass",  iclass,  0);
    chk("mr_rd",      rd_addr, 0);
    chk("mr_jtarget", jtarget, 0);
    chk("mr_opcode",  opcode,  0);
    start(32'h128, 32'h8D0B0004);
    tick();
    chk("mr_sb_clear_done",   done,   1);
    chk("mr_sb_clear_hazard", hazard, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
